// File: rtl/cim_pkg.sv
// Shared CIM datapath constants: default widths and plane-counter size.
package cim_pkg;
  localparam int MAC_W_DEF   = 14;
  localparam int IN_BITS_DEF = 8;
  localparam int ACC_W_DEF   = 24;
  // Wide enough for plane indices 0..15.
  localparam int CNT_W       = 4;
endpackage

// File: rtl/psum_out_reg.sv
// One-entry valid/ready output register for completed partial sums.
module psum_out_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Upstream only loads when the slot is empty or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/psum_shift_acc.sv
// Bit-serial shift-accumulate of per-plane MAC results, MSB plane first.
module psum_shift_acc
  import cim_pkg::*;
#(
  parameter int MAC_W   = MAC_W_DEF,
  parameter int IN_BITS = IN_BITS_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAC_W-1:0] mac_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mac_sus,
  input  logic             act_signed,
  input  logic             flush,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_BITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_sus;
  logic             r_act;

  logic             w_fire;
  logic             w_first;
  logic             w_last;
  logic             w_sus;
  logic             w_act;
  logic             w_sbit;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_ovalid;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LAST);

  // Plane 0 uses live modes; later planes use the latched copy.
  assign w_sus  = w_first ? mac_sus : r_sus;
  assign w_act  = w_first ? act_signed : r_act;
  assign w_sbit = w_sus & mac_in[MAC_W-1];

  assign in_ready = !flush &&
                    !(w_last && w_ovalid && !out_ready);
  assign w_fire   = in_valid && in_ready;

  always_comb begin
    w_ext     = {{(ACC_W-MAC_W){w_sbit}}, mac_in};
    w_acc_nxt = (r_acc << 1) + w_ext;
    if (w_first) begin
      w_acc_nxt = (w_first && w_act) ? -w_ext : w_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_sus <= 1'b0;
      r_act <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_fire) begin
      if (w_first) begin
        r_sus <= mac_sus;
        r_act <= act_signed;
      end
      if (w_last) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_nxt;
      end
    end
  end

  psum_out_reg #(
    .W (ACC_W)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_fire && w_last),
    .i_data  (w_acc_nxt),
    .i_ready (out_ready),
    .o_valid (w_ovalid),
    .o_data  (out_data)
  );

  assign out_valid = w_ovalid;

endmodule

// File: tb/tb_psum_shift_acc.sv
// Randomized and directed bench for psum_shift_acc with a plane-list model.
module tb_psum_shift_acc;

  localparam int MAC_W   = 14;
  localparam int IN_BITS = 8;
  localparam int ACC_W   = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [MAC_W-1:0] mac_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             mac_sus = 1'b0;
  logic             act_signed = 1'b0;
  logic             flush = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;

  always #5 clk = ~clk;

  psum_shift_acc #(
    .MAC_W   (MAC_W),
    .IN_BITS (IN_BITS),
    .ACC_W   (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mac_in     (mac_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mac_sus    (mac_sus),
    .act_signed (act_signed),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: weighted sum of plane values, MSB plane first.
  function automatic logic [ACC_W-1:0] ref_sum(
    input int unsigned pl [16], input bit sus, input bit act);
    longint s;
    longint v;
    longint term;
    s = 0;
    for (int i = 0; i < IN_BITS; i++) begin
      v = longint'(pl[i]);
      if (sus && v >= (64'sd1 << (MAC_W - 1)))
        v = v - (64'sd1 << MAC_W);
      term = v * (64'sd1 << (IN_BITS - 1 - i));
      if (i == 0 && act) term = -term;
      s = s + term;
    end
    return s[ACC_W-1:0];
  endfunction

  int               m_cnt = 0;
  int unsigned      m_pl [16];
  bit               m_sus = 0;
  bit               m_act = 0;
  bit               m_ovalid = 0;
  logic [ACC_W-1:0] m_odata = '0;
  bit               started = 0;
  logic [ACC_W-1:0] got [$];
  bit               m_fire, m_hs, m_ld;

  function automatic bit exp_ready();
    return !flush && !(m_cnt == IN_BITS - 1 && m_ovalid && !out_ready);
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_cnt    = 0;
      m_ovalid = 0;
      m_odata  = '0;
      m_sus    = 0;
      m_act    = 0;
    end else begin
      m_fire = in_valid && exp_ready();
      m_hs   = m_ovalid && out_ready;
      m_ld   = 0;
      if (m_hs) got.push_back(m_odata);
      if (flush) begin
        m_cnt = 0;
      end else if (m_fire) begin
        if (m_cnt == 0) begin
          m_sus = mac_sus;
          m_act = act_signed;
        end
        m_pl[m_cnt] = int'(mac_in);
        m_cnt++;
        if (m_cnt == IN_BITS) begin
          m_cnt = 0;
          m_ld  = 1;
        end
      end
      if (m_ld) begin
        m_odata  = ref_sum(m_pl, m_sus, m_act);
        m_ovalid = 1;
      end else if (m_hs) begin
        m_ovalid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_ovalid));
      if (m_ovalid) chk("out_data", 32'(out_data), 32'(m_odata));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input int unsigned mac);
    int n;
    in_valid = 1'b1;
    mac_in   = MAC_W'(mac);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("beat_timeout", 32'(n), 32'(0));
    step();
    in_valid = 1'b0;
  endtask

  task automatic vec(input int unsigned mac, input bit sus,
                     input bit act, input int n);
    mac_sus    = sus;
    act_signed = act;
    for (int i = 0; i < n; i++) beat(mac);
  endtask

  int base;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    step();

    vec(1, 0, 0, 8);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'd255);
    step();

    vec(1, 0, 1, 8);
    @(negedge clk);
    chk("t2_data", 32'(out_data), 32'h00FFFFFF);
    step();

    vec(14'h3FFF, 1, 0, 8);
    @(negedge clk);
    chk("t3_data", 32'(out_data), 32'h00FFFF01);
    step();
    step();

    base = got.size();
    out_ready = 1'b0;
    vec(1, 0, 0, 8);
    vec(2, 0, 0, 7);
    in_valid = 1'b1;
    mac_in   = MAC_W'(2);
    @(negedge clk);
    chk("t4_block", 32'(in_ready), 32'd0);
    chk("t4_hold", 32'(out_data), 32'd255);
    @(negedge clk);
    chk("t4_block2", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_rise", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_b_valid", 32'(out_valid), 32'd1);
    chk("t4_b_data", 32'(out_data), 32'd510);
    step();
    step();
    chk("t4_order0", 32'(got[base]), 32'd255);
    chk("t4_order1", 32'(got[base+1]), 32'd510);

    vec(5, 0, 0, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vec(2, 0, 0, 8);
    @(negedge clk);
    chk("t5_rst_data", 32'(out_data), 32'd510);
    step();

    out_ready = 1'b0;
    vec(1, 0, 0, 8);
    vec(2, 0, 0, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_fl_valid", 32'(out_valid), 32'd1);
    chk("t5_fl_data", 32'(out_data), 32'd255);
    step();
    out_ready = 1'b1;
    vec(2, 0, 0, 8);
    @(negedge clk);
    chk("t5_fl_sum", 32'(out_data), 32'd510);
    step();

    for (int c = 0; c < 4000; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 30) == 0);
      rst        = ($urandom_range(0, 300) == 0);
      mac_sus    = $urandom_range(0, 1) == 1;
      act_signed = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: mac_in = '1;
        1: mac_in = MAC_W'(14'h2000);
        default: mac_in = MAC_W'($urandom);
      endcase
      step();
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
